// File: rtl/core_pkg.sv
// Shared encodings for the core: funct3 access codes, writeback selects, FSM states.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package core_pkg;

   // RV32I load/store funct3 codes
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // Access size lives in funct3[1:0]; funct3[2] only selects zero-extension on loads
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Writeback source select
   localparam logic [1:0] REGSRC_ALU = 2'd0;
   localparam logic [1:0] REGSRC_MEM = 2'd1;
   localparam logic [1:0] REGSRC_IMM = 2'd2;
   localparam logic [1:0] REGSRC_PC4 = 2'd3;

   // Bit positions inside the 3-bit ValidReg vector
   localparam int VR_RD  = 0;
   localparam int VR_RS1 = 1;
   localparam int VR_RS2 = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // Halves need bit 0 clear, words need both low bits clear; bytes always fit
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         SZ_HALF: return lo[0];
         SZ_WORD: return lo != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_align.sv
// Extracts and extends the addressed byte/half/word from a 32-bit read word.
// Latency: purely combinational.
// Backpressure: none.
module load_align (
   input  logic [31:0] rdata,
   input  logic [1:0]  lane,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);
   import core_pkg::*;

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the lane, then sign- or zero-extend according to funct3
   always_comb begin
      byte_sel = rdata[7:0];
      case (lane)
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         2'd3:    byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
      half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         F3_LH:   data = {{16{half_sel[15]}}, half_sel};
         F3_LBU:  data = {24'd0, byte_sel};
         F3_LHU:  data = {16'd0, half_sel};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores on a req/ack data port and registers the WB-stage fields.
// Latency: 1 cycle for non-memory ops; 1 + cycles-to-ack for memory ops (minimum 2).
// Backpressure: mem_stall holds IF..MEM from the issue cycle until ack or timeout.
module mem_access_stage #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] MEM_ALU_result,
   input  logic [31:0] MEM_rs2_data,
   input  logic [31:0] MEM_pc,
   input  logic [31:0] MEM_pc_eximm,
   input  logic [2:0]  MEM_funct3,
   input  logic        MEM_MemRead,
   input  logic        MEM_MemWrite,
   input  logic [1:0]  MEM_RegSrc,
   input  logic [4:0]  MEM_rd,
   input  logic [2:0]  MEM_ValidReg,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_wstrb,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        mem_stall,
   output logic        misaligned,
   output logic        bus_err,
   output logic [4:0]  WB_rd,
   output logic [2:0]  WB_ValidReg,
   output logic [31:0] WB_rd_write_data
);
   import core_pkg::*;

   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       lane_q;
   logic [2:0]       f3_q;
   logic             access, mis, start, mis_now, ack_hit, timeout;
   logic [31:0]      wdata_n, wb_sel, load_data;
   logic [3:0]       wstrb_n;

   assign access  = (MEM_ValidReg != 3'b000) && (MEM_MemRead || MEM_MemWrite);
   assign mis     = is_misaligned(MEM_funct3[1:0], MEM_ALU_result[1:0]);
   assign start   = (state_q == ST_IDLE) && access && !mis;
   assign mis_now = (state_q == ST_IDLE) && access && mis;
   assign ack_hit = (state_q == ST_BUSY) && dmem_ack;
   // Timeout fires on the cycle the counter would reach TIMEOUT_CYCLES
   assign timeout = (state_q == ST_BUSY) && !dmem_ack && (cnt_q == CNT_LAST);

   load_align u_load_align (
      .rdata  (dmem_rdata),
      .lane   (lane_q),
      .funct3 (f3_q),
      .data   (load_data)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // FSM next state: issue on a clean access, return on ack or timeout
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_BUSY;
         ST_BUSY: if (dmem_ack || timeout) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: req straight from the state flop, stall until the access resolves
   always_comb begin
      dmem_req  = (state_q == ST_BUSY);
      mem_stall = 1'b0;
      case (state_q)
         ST_IDLE: mem_stall = start;
         ST_BUSY: mem_stall = !dmem_ack && !timeout;
         default: mem_stall = 1'b0;
      endcase
   end

   // Store lane replication and byte strobes from the low address bits
   always_comb begin
      wdata_n = MEM_rs2_data;
      wstrb_n = 4'hF;
      case (MEM_funct3[1:0])
         SZ_BYTE: begin
            wdata_n = {4{MEM_rs2_data[7:0]}};
            wstrb_n = 4'b0001 << MEM_ALU_result[1:0];
         end
         SZ_HALF: begin
            wdata_n = {2{MEM_rs2_data[15:0]}};
            wstrb_n = 4'b0011 << MEM_ALU_result[1:0];
         end
         default: begin
            wdata_n = MEM_rs2_data;
            wstrb_n = 4'hF;
         end
      endcase
   end

   // Writeback source for non-load results; a MEM select without a load writes 0
   always_comb begin
      case (MEM_RegSrc)
         REGSRC_ALU: wb_sel = MEM_ALU_result;
         REGSRC_IMM: wb_sel = MEM_pc_eximm;
         REGSRC_PC4: wb_sel = MEM_pc + 32'd4;
         default:    wb_sel = 32'd0;
      endcase
   end

   // Latch the request at issue so the port stays stable while BUSY; count wait cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         lane_q     <= 2'd0;
         f3_q       <= 3'd0;
         dmem_we    <= 1'b0;
         dmem_addr  <= 32'd0;
         dmem_wdata <= 32'd0;
         dmem_wstrb <= 4'd0;
         misaligned <= 1'b0;
         bus_err    <= 1'b0;
      end else begin
         misaligned <= mis_now;
         bus_err    <= timeout;
         if (start) begin
            cnt_q      <= '0;
            lane_q     <= MEM_ALU_result[1:0];
            f3_q       <= MEM_funct3;
            dmem_we    <= MEM_MemWrite;
            dmem_addr  <= {MEM_ALU_result[31:2], 2'b00};
            dmem_wdata <= wdata_n;
            dmem_wstrb <= wstrb_n;
         end else if (state_q == ST_BUSY) begin
            cnt_q <= (dmem_ack || timeout) ? '0 : cnt_q + CNT_W'(1);
         end
      end
   end

   // WB register: bubble on stall/abort/misalign so stale data is never re-forwarded
   always_ff @(posedge clk) begin
      if (rst) begin
         WB_rd            <= 5'd0;
         WB_ValidReg      <= 3'd0;
         WB_rd_write_data <= 32'd0;
      end else if (mem_stall || timeout || mis_now) begin
         WB_ValidReg <= 3'd0;
      end else begin
         WB_rd            <= MEM_rd;
         WB_ValidReg      <= MEM_ValidReg;
         WB_rd_write_data <= (ack_hit && !dmem_we) ? load_data : wb_sel;
      end
   end

endmodule
